wb_arbiter: RTL and testbench

// Round-robin Wishbone classic arbiter that shares the single master port of the

---
 rtl/wb_arbiter_if.sv | 58 +++++
 rtl/wb_arbiter.sv | 143 ++++++++++++++
 tb/tb_wb_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_if.sv
// -----------------------------------------------------------------------------
// wb_arbiter_if
// Bundle of every Wishbone classic signal around the round-robin arbiter: the
// per-master request side (m_wb_*) and the single downstream link to the bus
// mux master port (s_wb_*).
//
// Modports
//   slave  : the arbiter's view. It is the slave of the requesting masters and
//            drives the downstream link towards the mux.
//   master : the environment's view. It holds the requesting masters and the
//            mux that answers on the downstream link.
//
// Signals
//   m_wb_adr/dat [NUM_MASTERS][W]    per-master address / write data
//   m_wb_sel     [NUM_MASTERS][W/8]  per-master byte select
//   m_wb_we/cyc  [NUM_MASTERS]       per-master write enable / cycle request
//   m_wb_rdt     [NUM_MASTERS][W]    read data, non-zero only for the granted master
//   m_wb_ack/err [NUM_MASTERS]       ack / timeout error to the granted master
//   s_wb_adr/dat/sel/we/cyc          granted master's signals to the mux
//   s_wb_rdt/ack                     response from the mux
// -----------------------------------------------------------------------------
interface wb_arbiter_if #(
  parameter int NUM_MASTERS   = 2,
  parameter int WB_DATA_WIDTH = 32
);
  localparam int SW = WB_DATA_WIDTH >> 3;

  logic [WB_DATA_WIDTH-1:0] m_wb_adr [NUM_MASTERS];
  logic [WB_DATA_WIDTH-1:0] m_wb_dat [NUM_MASTERS];
  logic [SW-1:0]            m_wb_sel [NUM_MASTERS];
  logic [NUM_MASTERS-1:0]   m_wb_we;
  logic [NUM_MASTERS-1:0]   m_wb_cyc;
  logic [WB_DATA_WIDTH-1:0] m_wb_rdt [NUM_MASTERS];
  logic [NUM_MASTERS-1:0]   m_wb_ack;
  logic [NUM_MASTERS-1:0]   m_wb_err;

  logic [WB_DATA_WIDTH-1:0] s_wb_adr;
  logic [WB_DATA_WIDTH-1:0] s_wb_dat;
  logic [SW-1:0]            s_wb_sel;
  logic                     s_wb_we;
  logic                     s_wb_cyc;
  logic [WB_DATA_WIDTH-1:0] s_wb_rdt;
  logic                     s_wb_ack;

  modport slave (
    input  m_wb_adr, m_wb_dat, m_wb_sel, m_wb_we, m_wb_cyc,
    input  s_wb_rdt, s_wb_ack,
    output m_wb_rdt, m_wb_ack, m_wb_err,
    output s_wb_adr, s_wb_dat, s_wb_sel, s_wb_we, s_wb_cyc
  );

  modport master (
    output m_wb_adr, m_wb_dat, m_wb_sel, m_wb_we, m_wb_cyc,
    output s_wb_rdt, s_wb_ack,
    input  m_wb_rdt, m_wb_ack, m_wb_err,
    input  s_wb_adr, s_wb_dat, s_wb_sel, s_wb_we, s_wb_cyc
  );
endinterface

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
// Round-robin Wishbone classic arbiter sharing the single master port of the
// SERV address-decoding bus mux among NUM_MASTERS requesters. One master is
// granted per transaction and its signals are passed straight through. Every
// transaction is followed by at least one cycle with s_wb_cyc low, which the
// mux's toggling ack register needs. A watchdog ends transactions that are
// never acked with a one-cycle error to the granted master.
//
// Ports
//   wb_clk    in   bus clock, all state on the rising edge
//   wb_rst_n  in   asynchronous active-low reset
//   bus       wb_arbiter_if.slave: per-master request side and mux link
//   grant     out  current / last granted master index (debug)
//
// Parameters
//   NUM_MASTERS     number of requesters (>= 2)
//   WB_DATA_WIDTH   data / address width, sel is WB_DATA_WIDTH/8 wide
//   TIMEOUT_CYCLES  BUSY cycles without ack before error, 0 disables watchdog
// -----------------------------------------------------------------------------
module wb_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int WB_DATA_WIDTH  = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                           wb_clk,
  input  logic                           wb_rst_n,
  wb_arbiter_if.slave                    bus,
  output logic [$clog2(NUM_MASTERS)-1:0] grant
);

  localparam int GW = $clog2(NUM_MASTERS);
  // A zero timeout would give a zero-width timer, so keep at least one bit.
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TIMEOUT_VAL = TW'(TIMEOUT_CYCLES);
  // Starting "last" at the top index makes master 0 win the first tie.
  localparam logic [GW-1:0] LAST_RESET  = GW'(NUM_MASTERS - 1);

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  state_e        state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] last_q,  last_d;
  logic [TW-1:0] timer_q, timer_d;

  logic          pick_found;
  logic [GW-1:0] pick_idx;
  logic [GW-1:0] cand_idx;
  logic          timeout_hit;

  // Round-robin search: the first requester found scanning last+1, last+2, ...
  // wraps back to last itself, so a lone repeat requester is still served.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand_idx   = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      cand_idx = GW'((int'(last_q) + i) % NUM_MASTERS);
      if (!pick_found && bus.m_wb_cyc[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (timer_q == TIMEOUT_VAL);

  // Next-state and bus routing. Outputs are combinational from state_q so an
  // asynchronous reset clears the downstream cycle without waiting for a clock.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    timer_d = timer_q;

    bus.s_wb_adr = '0;
    bus.s_wb_dat = '0;
    bus.s_wb_sel = '0;
    bus.s_wb_we  = 1'b0;
    bus.s_wb_cyc = 1'b0;
    bus.m_wb_ack = '0;
    bus.m_wb_err = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      bus.m_wb_rdt[i] = '0;
    end

    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          timer_d = '0;
          state_d = BUSY;
        end
      end

      BUSY: begin
        bus.s_wb_adr = bus.m_wb_adr[grant_q];
        bus.s_wb_dat = bus.m_wb_dat[grant_q];
        bus.s_wb_sel = bus.m_wb_sel[grant_q];
        bus.s_wb_we  = bus.m_wb_we[grant_q];
        bus.s_wb_cyc = bus.m_wb_cyc[grant_q];
        bus.m_wb_ack[grant_q] = bus.s_wb_ack;
        bus.m_wb_rdt[grant_q] = bus.s_wb_rdt;

        // Ack beats abort beats timeout; every exit passes through IDLE,
        // which produces the mandatory cyc-low gap.
        if (bus.s_wb_ack) begin
          last_d  = grant_q;
          state_d = IDLE;
        end else if (!bus.m_wb_cyc[grant_q]) begin
          last_d  = grant_q;
          state_d = IDLE;
        end else if (timeout_hit) begin
          bus.m_wb_err[grant_q] = 1'b1;
          last_d  = grant_q;
          state_d = IDLE;
        end else if (timer_q != '1) begin
          timer_d = timer_q + TW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= LAST_RESET;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      timer_q <= timer_d;
    end
  end

  assign grant = grant_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter
// Bench for wb_arbiter with two masters and a 4-cycle watchdog. A small mux
// model answers on the downstream link with a registered ack after a
// programmable number of cycles and returns rdt = adr ^ RDT_KEY. Expected
// responses are queued when a request is issued; a monitor pops and compares
// them whenever the arbiter presents an ack or err to a master.
// -----------------------------------------------------------------------------
module tb_wb_arbiter;

  localparam int NM = 2;
  localparam int W  = 32;
  localparam int SW = W / 8;
  localparam int TO = 4;
  // Chosen so that address 0x2000_0010 reads back 0xDEADBEEF.
  localparam logic [W-1:0] RDT_KEY = 32'hFEAD_BEFF;

  localparam logic [W-1:0] A0 = 32'h1000_0000;  // reads 0xEEADBEFF
  localparam logic [W-1:0] A1 = 32'h3000_0004;  // reads 0xCEADBEFB

  logic                  wb_clk = 1'b0;
  logic                  wb_rst_n;
  logic [$clog2(NM)-1:0] grant;

  wb_arbiter_if #(.NUM_MASTERS(NM), .WB_DATA_WIDTH(W)) bus ();

  wb_arbiter #(
    .NUM_MASTERS   (NM),
    .WB_DATA_WIDTH (W),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .wb_clk  (wb_clk),
    .wb_rst_n(wb_rst_n),
    .bus     (bus),
    .grant   (grant)
  );

  always #5 wb_clk = ~wb_clk;

  typedef struct {
    int             m;
    bit             is_err;
    logic [W-1:0]   adr;
    logic [W-1:0]   dat;
    logic [W-1:0]   rdt;
    logic [SW-1:0]  sel;
    logic           we;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  int   pend      [NM];
  bit   done_flag [NM];

  // Mux model: registered ack, ack_delay extra wait cycles before acking.
  int   ack_delay = 1000;
  int   slv_cnt;
  logic slv_ack;

  always @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      slv_ack <= 1'b0;
      slv_cnt <= 0;
    end else if (bus.s_wb_cyc && !slv_ack) begin
      if (slv_cnt >= ack_delay) slv_ack <= 1'b1;
      else                      slv_cnt <= slv_cnt + 1;
    end else begin
      slv_ack <= 1'b0;
      slv_cnt <= 0;
    end
  end

  assign bus.s_wb_ack = slv_ack;
  assign bus.s_wb_rdt = bus.s_wb_adr ^ RDT_KEY;

  task automatic checkOutput(input string name, input logic [W-1:0] actual,
                             input logic [W-1:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%08h want=0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int m, input logic [W-1:0] adr, input logic we,
                               input logic [W-1:0] dat, input logic [SW-1:0] sel,
                               input int count);
    bus.m_wb_adr[m] = adr;
    bus.m_wb_dat[m] = dat;
    bus.m_wb_sel[m] = sel;
    bus.m_wb_we[m]  = we;
    pend[m]         = count;
    bus.m_wb_cyc[m] = 1'b1;
  endtask

  task automatic expect_txn(input int m, input bit is_err, input logic [W-1:0] adr,
                            input logic we, input logic [W-1:0] dat,
                            input logic [SW-1:0] sel, input logic [W-1:0] rdt);
    exp_t e;
    e.m = m; e.is_err = is_err; e.adr = adr; e.we = we;
    e.dat = dat; e.sel = sel; e.rdt = rdt;
    exp_q.push_back(e);
  endtask

  // One bus cycle: note responses mid-cycle, update master requests just
  // after the edge, then settle so checks see stable combinational outputs.
  task automatic cycle_step();
    @(negedge wb_clk);
    for (int i = 0; i < NM; i++)
      if (bus.m_wb_ack[i] || bus.m_wb_err[i]) done_flag[i] = 1'b1;
    @(posedge wb_clk);
    #1;
    for (int i = 0; i < NM; i++) begin
      if (done_flag[i]) begin
        if (pend[i] > 0) pend[i]--;
        done_flag[i] = 1'b0;
      end
      bus.m_wb_cyc[i] = (pend[i] > 0);
    end
    #1;
  endtask

  function automatic bit any_pending();
    bit r = 1'b0;
    for (int i = 0; i < NM; i++) if (pend[i] > 0) r = 1'b1;
    return r;
  endfunction

  task automatic drain(input int budget);
    int n = 0;
    while (any_pending() && n < budget) begin
      cycle_step();
      n++;
    end
    total++;
    if (any_pending()) begin
      bad++;
      $display("[TB] FAIL drain_timeout: pending m0=%0d m1=%0d want 0/0", pend[0], pend[1]);
    end
    cycle_step();
  endtask

  task automatic apply_reset();
    wb_rst_n = 1'b0;
    cycle_step();
    checkOutput("rst_grant", 32'(grant), 32'd0);
    wb_rst_n = 1'b1;
    cycle_step();
  endtask

  // Scoreboard monitor plus the idle-gap rule after every response.
  initial begin : monitor
    exp_t e;
    bit   prev_done;
    prev_done = 1'b0;
    forever begin
      @(negedge wb_clk);
      if (!wb_rst_n) begin
        prev_done = 1'b0;
        continue;
      end
      if (prev_done) checkOutput("idle_gap_cyc", 32'(bus.s_wb_cyc), 32'd0);
      prev_done = |(bus.m_wb_ack | bus.m_wb_err);
      if (prev_done) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_resp: ack=%b err=%b want none",
                   bus.m_wb_ack, bus.m_wb_err);
        end else begin
          e = exp_q.pop_front();
          checkOutput("sb_ack_vec", 32'(bus.m_wb_ack), e.is_err ? 32'd0 : (32'd1 << e.m));
          checkOutput("sb_err_vec", 32'(bus.m_wb_err), e.is_err ? (32'd1 << e.m) : 32'd0);
          checkOutput("sb_adr", bus.s_wb_adr, e.adr);
          checkOutput("sb_we", 32'(bus.s_wb_we), 32'(e.we));
          if (!e.is_err) checkOutput("sb_rdt", bus.m_wb_rdt[e.m], e.rdt);
          for (int j = 0; j < NM; j++)
            if (j != e.m) checkOutput("sb_other_rdt", bus.m_wb_rdt[j], 32'd0);
          if (e.we) begin
            checkOutput("sb_dat", bus.s_wb_dat, e.dat);
            checkOutput("sb_sel", 32'(bus.s_wb_sel), 32'(e.sel));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL global_timeout: simulation still running");
    $fatal(1, "[TB] global timeout");
  end

  initial begin : stimulus
    wb_rst_n = 1'b0;
    for (int i = 0; i < NM; i++) begin
      bus.m_wb_adr[i] = '0;
      bus.m_wb_dat[i] = '0;
      bus.m_wb_sel[i] = '0;
      pend[i]         = 0;
      done_flag[i]    = 1'b0;
    end
    bus.m_wb_we  = '0;
    bus.m_wb_cyc = '0;
    @(posedge wb_clk);
    #2;

    // Reset state
    checkOutput("rst_s_cyc", 32'(bus.s_wb_cyc), 32'd0);
    checkOutput("rst_s_adr", bus.s_wb_adr, 32'd0);
    checkOutput("rst_grant", 32'(grant), 32'd0);
    checkOutput("rst_ack", 32'(bus.m_wb_ack), 32'd0);
    checkOutput("rst_err", 32'(bus.m_wb_err), 32'd0);
    checkOutput("rst_rdt0", bus.m_wb_rdt[0], 32'd0);
    cycle_step();
    wb_rst_n = 1'b1;
    cycle_step();

    // Single read with mux latency
    $display("[TB] single read");
    ack_delay = 0;
    applyStimulus(0, 32'h2000_0010, 1'b0, 32'd0, 4'hF, 1);
    expect_txn(0, 1'b0, 32'h2000_0010, 1'b0, 32'd0, 4'hF, 32'hDEAD_BEEF);
    checkOutput("t1_c0_cyc", 32'(bus.s_wb_cyc), 32'd0);
    cycle_step();
    checkOutput("t1_c1_cyc", 32'(bus.s_wb_cyc), 32'd1);
    checkOutput("t1_c1_adr", bus.s_wb_adr, 32'h2000_0010);
    checkOutput("t1_c1_ack", 32'(bus.m_wb_ack), 32'd0);
    cycle_step();
    checkOutput("t1_c2_ack", 32'(bus.m_wb_ack), 32'd1);
    checkOutput("t1_c2_rdt", bus.m_wb_rdt[0], 32'hDEAD_BEEF);
    cycle_step();
    checkOutput("t1_c3_cyc", 32'(bus.s_wb_cyc), 32'd0);
    cycle_step();

    // Two masters holding cyc: grants alternate 0,1,0,1
    $display("[TB] alternating grants");
    apply_reset();
    applyStimulus(0, A0, 1'b0, 32'd0, 4'hF, 2);
    applyStimulus(1, A1, 1'b1, 32'h0BAD_F00D, 4'b0011, 2);
    expect_txn(0, 1'b0, A0, 1'b0, 32'd0, 4'hF, 32'hEEAD_BEFF);
    expect_txn(1, 1'b0, A1, 1'b1, 32'h0BAD_F00D, 4'b0011, 32'hCEAD_BEFB);
    expect_txn(0, 1'b0, A0, 1'b0, 32'd0, 4'hF, 32'hEEAD_BEFF);
    expect_txn(1, 1'b0, A1, 1'b1, 32'h0BAD_F00D, 4'b0011, 32'hCEAD_BEFB);
    cycle_step();
    checkOutput("t2_first_grant", 32'(grant), 32'd0);
    drain(40);

    // Late request from m1 waits for m0
    $display("[TB] request while busy");
    ack_delay = 2;
    bus.m_wb_we = '0;
    applyStimulus(0, A0, 1'b0, 32'd0, 4'hF, 1);
    expect_txn(0, 1'b0, A0, 1'b0, 32'd0, 4'hF, 32'hEEAD_BEFF);
    expect_txn(1, 1'b0, A1, 1'b0, 32'd0, 4'hF, 32'hCEAD_BEFB);
    cycle_step();
    applyStimulus(1, A1, 1'b0, 32'd0, 4'hF, 1);
    checkOutput("t3_c1_grant", 32'(grant), 32'd0);
    checkOutput("t3_c1_adr", bus.s_wb_adr, A0);
    cycle_step();
    checkOutput("t3_c2_ack", 32'(bus.m_wb_ack), 32'd0);
    cycle_step();
    cycle_step();
    cycle_step();
    checkOutput("t3_c5_cyc", 32'(bus.s_wb_cyc), 32'd0);
    cycle_step();
    checkOutput("t3_c6_grant", 32'(grant), 32'd1);
    checkOutput("t3_c6_adr", bus.s_wb_adr, A1);
    drain(40);

    // Watchdog: never acked, error in BUSY cycle 5
    $display("[TB] timeout");
    ack_delay = 1000;
    applyStimulus(0, A0, 1'b0, 32'd0, 4'hF, 1);
    expect_txn(0, 1'b1, A0, 1'b0, 32'd0, 4'hF, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      cycle_step();
      checkOutput("t4_busy_cyc", 32'(bus.s_wb_cyc), 32'd1);
      checkOutput("t4_busy_err", 32'(bus.m_wb_err), 32'd0);
    end
    cycle_step();
    checkOutput("t4_c5_err", 32'(bus.m_wb_err), 32'd1);
    checkOutput("t4_c5_ack", 32'(bus.m_wb_ack), 32'd0);
    cycle_step();
    checkOutput("t4_c6_cyc", 32'(bus.s_wb_cyc), 32'd0);
    ack_delay = 0;
    applyStimulus(0, A0, 1'b0, 32'd0, 4'hF, 1);
    expect_txn(0, 1'b0, A0, 1'b0, 32'd0, 4'hF, 32'hEEAD_BEFF);
    drain(20);

    // Ack arriving exactly at the timeout wins
    $display("[TB] ack at timeout");
    ack_delay = 3;
    applyStimulus(0, A0, 1'b0, 32'd0, 4'hF, 1);
    expect_txn(0, 1'b0, A0, 1'b0, 32'd0, 4'hF, 32'hEEAD_BEFF);
    for (int k = 1; k <= 5; k++) cycle_step();
    checkOutput("t5_c5_ack", 32'(bus.m_wb_ack), 32'd1);
    checkOutput("t5_c5_err", 32'(bus.m_wb_err), 32'd0);
    drain(20);

    // Abort: m0 drops cyc in BUSY, then m1 is served next
    $display("[TB] abort");
    ack_delay = 1000;
    applyStimulus(0, A0, 1'b0, 32'd0, 4'hF, 1);
    cycle_step();
    cycle_step();
    checkOutput("t5b_c2_cyc", 32'(bus.s_wb_cyc), 32'd1);
    pend[0] = 0;
    bus.m_wb_cyc[0] = 1'b0;
    #1;
    checkOutput("t5b_drop_cyc", 32'(bus.s_wb_cyc), 32'd0);
    cycle_step();
    checkOutput("t5b_c3_ack", 32'(bus.m_wb_ack), 32'd0);
    checkOutput("t5b_c3_err", 32'(bus.m_wb_err), 32'd0);
    ack_delay = 0;
    applyStimulus(1, A1, 1'b0, 32'd0, 4'hF, 1);
    expect_txn(1, 1'b0, A1, 1'b0, 32'd0, 4'hF, 32'hCEAD_BEFB);
    cycle_step();
    checkOutput("t5b_c4_grant", 32'(grant), 32'd1);
    drain(20);

    // Reset in the middle of a BUSY transfer
    $display("[TB] reset mid-busy");
    ack_delay = 1000;
    applyStimulus(1, A1, 1'b0, 32'd0, 4'hF, 1);
    cycle_step();
    checkOutput("t6_c1_grant", 32'(grant), 32'd1);
    checkOutput("t6_c1_cyc", 32'(bus.s_wb_cyc), 32'd1);
    #1;
    wb_rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_cyc", 32'(bus.s_wb_cyc), 32'd0);
    checkOutput("t6_rst_adr", bus.s_wb_adr, 32'd0);
    checkOutput("t6_rst_grant", 32'(grant), 32'd0);
    checkOutput("t6_rst_ack", 32'(bus.m_wb_ack), 32'd0);
    checkOutput("t6_rst_err", 32'(bus.m_wb_err), 32'd0);
    checkOutput("t6_rst_rdt1", bus.m_wb_rdt[1], 32'd0);
    cycle_step();
    cycle_step();
    wb_rst_n = 1'b1;
    ack_delay = 0;
    applyStimulus(0, A0, 1'b0, 32'd0, 4'hF, 1);
    expect_txn(0, 1'b0, A0, 1'b0, 32'd0, 4'hF, 32'hEEAD_BEFF);
    expect_txn(1, 1'b0, A1, 1'b0, 32'd0, 4'hF, 32'hCEAD_BEFB);
    cycle_step();
    checkOutput("t6_tie_grant", 32'(grant), 32'd0);
    checkOutput("t6_tie_adr", bus.s_wb_adr, A0);
    drain(30);

    checkOutput("sb_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
